pipe_hazard_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Generates per-latch enables and flushes from three sources:
  - the data-memory req/ack handshake for the access held in the EX/MEM latch (mem_read_reg/mem_write_reg);
  - load-use hazard detection;
  - taken-branch flush.
- Also keeps a sticky memory-timeout error flag and a saturating stall-cycle counter.

---
 rtl/pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central sequencing controller for the 5-stage pipeline latches and PC.
//   It combines three stall/flush sources into per-latch enables and flushes:
//     - the data-memory req/ack handshake for the access in EX/MEM;
//     - load-use hazard detection between ID/EX and IF/ID;
//     - taken-branch flush.
//   It also keeps a sticky memory-timeout flag and a saturating count of
//   stall cycles.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   mem_read_reg         load held in EX/MEM
//   mem_write_reg        store held in EX/MEM
//   ex_mem_read, ex_rt   load in ID/EX and its destination register
//   id_rs, id_rt         sources of the IF/ID instruction
//   id_uses_rt           IF/ID instruction reads rt
//   branch_taken         branch resolved taken in EX
//   dmem_ack             data memory completes its access this cycle
//   pc_en .. mem_wb_en   PC and latch enables
//   if_id_flush          load NOP into IF/ID
//   id_ex_flush          load bubble into ID/EX
//   dmem_req             data memory request (same-cycle, Mealy)
//   mem_busy             waiting for a memory acknowledge
//   mem_err              sticky memory-timeout flag
//   stall_count          saturating stall-cycle counter
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read_reg,
  input  logic             mem_write_reg,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             branch_taken,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             dmem_req,
  output logic             mem_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             err_set;

  logic access;
  logic in_wait;
  logic req_raw;
  logic timeout;
  logic done;
  logic freeze;
  logic hazard;
  logic stall;

  assign access  = mem_read_reg | mem_write_reg;
  assign in_wait = (state == ST_WAIT);
  assign req_raw = (~in_wait & access) | in_wait;
  assign timeout = in_wait & (timer == TMR_LAST);
  assign done    = dmem_ack | timeout;
  assign freeze  = req_raw & ~done;

  assign hazard = ex_mem_read & (ex_rt != '0) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // A hazard coinciding with a taken branch costs no stall: the dependent
  // instruction is on the wrong path and gets flushed instead.
  assign stall = freeze | (hazard & ~branch_taken);

  assign dmem_req = rst & req_raw;
  assign mem_busy = in_wait;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    err_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access && !dmem_ack) begin
          state_nxt = ST_WAIT;
          timer_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else if (timeout) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
          err_set   = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_err <= 1'b0;
    end else if (err_set) begin
      mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // Enables and flushes are gated by rst so the pipeline is held while the
  // reset pin is low, not only after the next clock edge.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      if (freeze) begin
        // Whole pipeline held; branch/hazard inputs remain stable meanwhile.
      end else if (branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hazard) begin
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read_reg, mem_write_reg, ex_mem_read;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       id_uses_rt, branch_taken, dmem_ack;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, dmem_req, mem_busy, mem_err;
  logic [15:0] stall_count;

  logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
  logic        s_if_id_flush, s_id_ex_flush, s_dmem_req, s_mem_busy, s_mem_err;
  logic [3:0]  s_stall_count;

  logic [6:0] ctl;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  localparam logic [6:0] FROZEN = 7'b0000000;
  localparam logic [6:0] EN_ALL = 7'b1111100;
  localparam logic [6:0] BRANCH = 7'b1111111;
  localparam logic [6:0] HAZ    = 7'b0011101;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .TIMEOUT(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .mem_read_reg(mem_read_reg), .mem_write_reg(mem_write_reg),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .dmem_req(dmem_req), .mem_busy(mem_busy), .mem_err(mem_err),
    .stall_count(stall_count)
  );

  // Narrow-counter copy used to reach saturation in a few cycles.
  pipe_hazard_ctrl #(.REG_W(5), .TIMEOUT(16), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .mem_read_reg(mem_read_reg), .mem_write_reg(mem_write_reg),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .dmem_ack(dmem_ack),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en),
    .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .dmem_req(s_dmem_req), .mem_busy(s_mem_busy), .mem_err(s_mem_err),
    .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_read_reg = 0; mem_write_reg = 0; ex_mem_read = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    branch_taken = 0; dmem_ack = 0;
  endtask

  initial begin
    rst = 0;
    clear_in();

    // 1. reset with a pending access
    mem_read_reg = 1;
    tick(); tick(); #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'(FROZEN));
    chk("rst_cnt", 32'(stall_count), 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    tick();
    rst = 1; #1;
    chk("rel_req", 32'(dmem_req), 32'd1);
    chk("rel_ctl", 32'(ctl), 32'(FROZEN));
    tick();                                  // now WAIT, count 1
    dmem_ack = 1; #1;
    chk("rel_ack_ctl", 32'(ctl), 32'(EN_ALL));
    chk("rel_ack_busy", 32'(mem_busy), 32'd1);
    tick(); clear_in(); #1;
    chk("rel_cnt", 32'(stall_count), 32'd1);
    chk("rel_idle", 32'(mem_busy), 32'd0);

    // 2. zero-wait store
    mem_write_reg = 1; dmem_ack = 1; #1;
    chk("zw_req", 32'(dmem_req), 32'd1);
    chk("zw_ctl", 32'(ctl), 32'(EN_ALL));
    chk("zw_busy", 32'(mem_busy), 32'd0);
    tick(); clear_in(); #1;
    chk("zw_busy2", 32'(mem_busy), 32'd0);
    chk("zw_cnt", 32'(stall_count), 32'd1);

    // 3. load acked 3 cycles after the request
    mem_read_reg = 1; #1;
    chk("w3_c1_ctl", 32'(ctl), 32'(FROZEN));
    chk("w3_c1_busy", 32'(mem_busy), 32'd0);
    tick();
    chk("w3_c2_ctl", 32'(ctl), 32'(FROZEN));
    chk("w3_c2_busy", 32'(mem_busy), 32'd1);
    tick();
    chk("w3_c3_ctl", 32'(ctl), 32'(FROZEN));
    chk("w3_c3_busy", 32'(mem_busy), 32'd1);
    tick();
    dmem_ack = 1; #1;
    chk("w3_ack_ctl", 32'(ctl), 32'(EN_ALL));
    tick(); clear_in(); #1;
    chk("w3_cnt", 32'(stall_count), 32'd4);
    chk("w3_idle", 32'(mem_busy), 32'd0);

    // 4. load-use hazard
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; #1;
    chk("hz_rs_ctl", 32'(ctl), 32'(HAZ));
    tick();
    ex_mem_read = 0; #1;                     // load has moved on
    chk("hz_after_ctl", 32'(ctl), 32'(EN_ALL));
    chk("hz_cnt", 32'(stall_count), 32'd5);
    ex_mem_read = 1; ex_rt = 0; id_rs = 0; #1;
    chk("hz_r0_ctl", 32'(ctl), 32'(EN_ALL));
    ex_rt = 7; id_rs = 1; id_rt = 7; id_uses_rt = 0; #1;
    chk("hz_rt_unused", 32'(ctl), 32'(EN_ALL));
    id_uses_rt = 1; #1;
    chk("hz_rt_ctl", 32'(ctl), 32'(HAZ));
    tick(); clear_in(); #1;
    chk("hz_cnt2", 32'(stall_count), 32'd6);

    // 5. branch beats hazard; branch deferred during WAIT
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; branch_taken = 1; #1;
    chk("br_hz_ctl", 32'(ctl), 32'(BRANCH));
    tick(); clear_in(); #1;
    chk("br_hz_cnt", 32'(stall_count), 32'd6);
    mem_read_reg = 1; branch_taken = 1; #1;
    chk("br_w_c1", 32'(ctl), 32'(FROZEN));
    tick();
    chk("br_w_c2", 32'(ctl), 32'(FROZEN));
    tick();
    dmem_ack = 1; #1;
    chk("br_w_ack", 32'(ctl), 32'(BRANCH));
    tick(); clear_in(); #1;
    chk("br_w_cnt", 32'(stall_count), 32'd8);
    chk("sat_cnt_8", 32'(s_stall_count), 32'd8);

    // reset asserted mid-WAIT
    mem_read_reg = 1;
    tick();
    chk("mr_busy", 32'(mem_busy), 32'd1);
    rst = 0; #1;
    chk("mr_busy0", 32'(mem_busy), 32'd0);
    chk("mr_req0", 32'(dmem_req), 32'd0);
    chk("mr_cnt0", 32'(stall_count), 32'd0);
    tick();
    rst = 1; #1;
    chk("mr_req1", 32'(dmem_req), 32'd1);
    chk("mr_busy1", 32'(mem_busy), 32'd0);
    dmem_ack = 1; #1;
    chk("mr_ack_ctl", 32'(ctl), 32'(EN_ALL));
    tick(); clear_in(); #1;
    chk("mr_cnt", 32'(stall_count), 32'd0);

    // back-to-back accesses: new request issued from IDLE right after ack
    mem_read_reg = 1;
    tick();
    dmem_ack = 1;
    tick();
    dmem_ack = 0; #1;
    chk("b2b_req", 32'(dmem_req), 32'd1);
    chk("b2b_busy", 32'(mem_busy), 32'd0);
    chk("b2b_ctl", 32'(ctl), 32'(FROZEN));
    tick();
    dmem_ack = 1;
    tick(); clear_in(); #1;
    chk("b2b_cnt", 32'(stall_count), 32'd2);

    // 6. timeout: 1 IDLE + 15 WAIT cycles frozen, then the 16th WAIT cycle advances
    mem_read_reg = 1; #1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_frz%0d", i), 32'(ctl), 32'(FROZEN));
      tick();
    end
    chk("to_ctl", 32'(ctl), 32'(EN_ALL));
    chk("to_busy", 32'(mem_busy), 32'd1);
    chk("to_err0", 32'(mem_err), 32'd0);
    tick();
    mem_read_reg = 0; #1;
    chk("to_err1", 32'(mem_err), 32'd1);
    chk("to_idle", 32'(mem_busy), 32'd0);
    chk("to_cnt", 32'(stall_count), 32'd18);
    tick();
    chk("to_err_sticky", 32'(mem_err), 32'd1);

    // saturation of the narrow counter
    chk("sat_cnt_15", 32'(s_stall_count), 32'd15);
    ex_mem_read = 1; ex_rt = 3; id_rs = 3;
    tick(); clear_in(); #1;
    chk("sat_hold", 32'(s_stall_count), 32'd15);
    chk("sat_main", 32'(stall_count), 32'd19);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
